filterbank_merge: RTL

//  Consumes the two filterbank-half output streams (even filters 0,2..30 and
//  odd filters 1,3..31) and re-emits them as one in-order 32-coefficient frame
//  (0,1,2..31) with valid/last, ready for the log/DCT stages. Half outputs

---
 rtl/filterbank_merge_if.sv | 37 +++
 rtl/filterbank_merge.sv | 95 +++++++++
 2 files changed

// File: rtl/filterbank_merge_if.sv
// Filterbank merge bus: two half-bank input
// streams in, one ordered coefficient stream out.
interface filterbank_merge_if #(
  parameter int I_BW = 32,
  parameter int O_BW = 32
);
  logic [I_BW-1:0] even_data_i;
  logic            even_valid_i;
  logic [I_BW-1:0] odd_data_i;
  logic            odd_valid_i;
  logic [O_BW-1:0] data_o;
  logic            valid_o;
  logic            last_o;
  logic            overflow_o;

  modport master (
    output even_data_i,
    output even_valid_i,
    output odd_data_i,
    output odd_valid_i,
    input  data_o,
    input  valid_o,
    input  last_o,
    input  overflow_o
  );

  modport slave (
    input  even_data_i,
    input  even_valid_i,
    input  odd_data_i,
    input  odd_valid_i,
    output data_o,
    output valid_o,
    output last_o,
    output overflow_o
  );
endinterface

// File: rtl/filterbank_merge.sv
// Merges even/odd filterbank halves into one
// in-order coefficient frame via two small FIFOs.
module filterbank_merge #(
  parameter int I_BW       = 32,
  parameter int O_BW       = 32,
  parameter int NUM_COEF   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk_i,
  input logic rst_n_i,
  input logic en_i,
  filterbank_merge_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(NUM_COEF);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_COEF - 1);

  logic [I_BW-1:0] mem [2][FIFO_DEPTH];
  logic [AW-1:0]   wp [2];
  logic [AW-1:0]   rp [2];
  logic [CW-1:0]   cnt [2];
  logic [IW-1:0]   idx;

  logic [1:0]      vin;
  logic [I_BW-1:0] din [2];
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      lost;
  logic            sel;
  logic [I_BW-1:0] head;

  // Pick the source half from idx parity and
  // decide push/pop/drop for each half FIFO.
  always_comb begin
    vin    = {bus.odd_valid_i, bus.even_valid_i};
    din[0] = bus.even_data_i;
    din[1] = bus.odd_data_i;
    sel    = idx[0];
    push   = '0;
    pop    = '0;
    lost   = '0;
    for (int h = 0; h < 2; h++) begin
      pop[h]  = (int'(sel) == h) &&
                (cnt[h] != '0);
      push[h] = vin[h] &&
                ((cnt[h] != FULL) || pop[h]);
      lost[h] = vin[h] &&
                (cnt[h] == FULL) && !pop[h];
    end
    head = mem[sel][rp[sel]];
  end

  // FIFO storage; stale words are never read
  // because the pointers are cleared on reset.
  always_ff @(posedge clk_i) begin
    for (int h = 0; h < 2; h++) begin
      if (push[h]) mem[h][wp[h]] <= din[h];
    end
  end

  // Pointers, counts, index and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !en_i) begin
      for (int h = 0; h < 2; h++) begin
        wp[h]  <= '0;
        rp[h]  <= '0;
        cnt[h] <= '0;
      end
      idx            <= '0;
      bus.data_o     <= '0;
      bus.valid_o    <= 1'b0;
      bus.last_o     <= 1'b0;
      bus.overflow_o <= 1'b0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (push[h]) wp[h] <= wp[h] + 1'b1;
        if (pop[h])  rp[h] <= rp[h] + 1'b1;
        if (push[h] && !pop[h])
          cnt[h] <= cnt[h] + 1'b1;
        else if (pop[h] && !push[h])
          cnt[h] <= cnt[h] - 1'b1;
      end
      if (|lost) bus.overflow_o <= 1'b1;
      bus.valid_o <= |pop;
      bus.last_o  <= (|pop) && (idx == LAST_IDX);
      if (|pop) begin
        bus.data_o <= O_BW'(head);
        idx <= (idx == LAST_IDX) ? '0
                                 : idx + 1'b1;
      end
    end
  end
endmodule
